// File: rtl/trap_csr_unit.sv
// Machine-mode trap unit: takes exceptions and interrupts, executes MRET,
// and holds the M-mode CSR file that Zicsr instructions read and write.
module trap_csr_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            exc_valid,
  input  logic [5:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] int_pc,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            irq_ext,
  input  logic            mret,
  input  logic            csr_we,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_st_mie, r_st_mpie;
  logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [63:0]     r_mcycle;
  logic            r_redirect, r_busy;
  logic [XLEN-1:0] r_redirect_pc;

  logic            w_redirect_nxt, w_busy_nxt;
  logic [XLEN-1:0] w_redirect_pc_nxt;
  logic [XLEN-1:0] w_mip, w_mstatus, w_pend, w_rdata, w_wval, w_base, w_trap_pc;
  logic            w_known, w_illegal, w_irq, w_idle;
  logic            w_do_exc, w_do_irq, w_do_mret, w_do_csr;
  logic [4:0]      w_irq_code;

  assign w_mip     = {{(XLEN-12){1'b0}}, irq_ext, 3'b000, irq_timer, 3'b000, irq_sw, 3'b000};
  // MPP is hardwired to 2'b11 (M-mode only)
  assign w_mstatus = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, r_st_mpie, 3'b000, r_st_mie, 3'b000};
  assign w_pend    = r_mie & w_mip;
  assign w_irq     = r_st_mie & (|w_pend);
  assign w_irq_code = w_pend[11] ? 5'd11 : (w_pend[3] ? 5'd3 : 5'd7);

  // CSR read mux; anything not listed is unimplemented
  always_comb begin
    w_rdata = '0;
    w_known = 1'b1;
    case (csr_addr)
      12'h300: w_rdata = w_mstatus;
      12'h301: w_rdata = 32'h4000_0100;
      12'h304: w_rdata = r_mie;
      12'h305: w_rdata = r_mtvec;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mtval;
      12'h344: w_rdata = w_mip;
      12'hB00: w_rdata = r_mcycle[31:0];
      12'hB80: w_rdata = r_mcycle[63:32];
      12'hF11, 12'hF12, 12'hF13: w_rdata = '0;
      12'hF14: w_rdata = HART_ID;
      default: w_known = 1'b0;
    endcase
  end

  // an RS/RC with a zero mask still counts as a write here
  assign w_illegal   = !w_known || (csr_op != 2'b00 && csr_addr[11:10] == 2'b11);
  assign csr_rdata   = w_rdata;
  assign csr_illegal = w_illegal;

  // new value for RW / RS / RC
  always_comb begin
    w_wval = w_rdata;
    case (csr_op)
      2'b01:   w_wval = csr_wdata;
      2'b10:   w_wval = w_rdata | csr_wdata;
      2'b11:   w_wval = w_rdata & ~csr_wdata;
      default: w_wval = w_rdata;
    endcase
  end

  // one event per cycle, only while idle: exception > interrupt > mret > csr write
  assign w_idle    = (r_state == S_IDLE);
  assign w_do_exc  = w_idle && exc_valid;
  assign w_do_irq  = w_idle && !exc_valid && w_irq;
  assign w_do_mret = w_idle && !exc_valid && !w_irq && mret;
  assign w_do_csr  = w_idle && !exc_valid && !w_irq && !mret && csr_we &&
                     (csr_op != 2'b00) && !w_illegal;

  // vectored mode offsets only interrupts; exceptions always land on the base
  assign w_base    = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_trap_pc = (w_do_irq && r_mtvec[0]) ?
                     w_base + {{(XLEN-7){1'b0}}, w_irq_code, 2'b00} : w_base;

  // next state and next registered outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_redirect_nxt    = 1'b0;
    w_busy_nxt        = 1'b0;
    w_redirect_pc_nxt = r_redirect_pc;
    case (r_state)
      S_IDLE: begin
        if (w_do_exc || w_do_irq) begin
          w_state_nxt       = S_TRAP;
          w_redirect_nxt    = 1'b1;
          w_busy_nxt        = 1'b1;
          w_redirect_pc_nxt = w_trap_pc;
        end else if (w_do_mret) begin
          w_state_nxt       = S_RET;
          w_redirect_nxt    = 1'b1;
          w_busy_nxt        = 1'b1;
          w_redirect_pc_nxt = r_mepc;
        end
      end
      S_TRAP, S_RET: w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  // state register and redirect outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state       <= S_IDLE;
      r_redirect    <= 1'b0;
      r_busy        <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_redirect    <= w_redirect_nxt;
      r_busy        <= w_busy_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
    end
  end

  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign busy        = r_busy;

  // CSR file: trap/mret side effects, Zicsr writes, free-running mcycle
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_st_mie   <= 1'b0;
      r_st_mpie  <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= {RESET_MTVEC[XLEN-1:2], 2'b00};
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mcycle   <= '0;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
      if (w_do_exc) begin
        r_mcause  <= {{(XLEN-6){1'b0}}, exc_code};
        r_mepc    <= {exc_pc[XLEN-1:2], 2'b00};
        r_mtval   <= exc_tval;
        r_st_mpie <= r_st_mie;
        r_st_mie  <= 1'b0;
      end else if (w_do_irq) begin
        r_mcause  <= {1'b1, {(XLEN-6){1'b0}}, w_irq_code};
        r_mepc    <= {int_pc[XLEN-1:2], 2'b00};
        r_mtval   <= '0;
        r_st_mpie <= r_st_mie;
        r_st_mie  <= 1'b0;
      end else if (w_do_mret) begin
        r_st_mie  <= r_st_mpie;
        r_st_mpie <= 1'b1;
      end else if (w_do_csr) begin
        case (csr_addr)
          12'h300: begin
            r_st_mie  <= w_wval[3];
            r_st_mpie <= w_wval[7];
          end
          12'h304: r_mie      <= w_wval & 32'h0000_0888;
          // reserved modes 2/3 fall back to direct
          12'h305: r_mtvec    <= {w_wval[XLEN-1:2], 1'b0, w_wval[1] ? 1'b0 : w_wval[0]};
          12'h340: r_mscratch <= w_wval;
          12'h341: r_mepc     <= {w_wval[XLEN-1:2], 2'b00};
          12'h342: r_mcause   <= w_wval;
          12'h343: r_mtval    <= w_wval;
          12'hB00: r_mcycle   <= {r_mcycle[63:32], w_wval};
          // low half still counts but the carry into the written high half is dropped
          12'hB80: r_mcycle   <= {w_wval, r_mcycle[31:0] + 32'd1};
          default: ;
        endcase
      end
    end
  end

endmodule
